seq_lock_ctrl: RTL
==================

# seq_lock_ctrl

Sequencing controller for the 4-bit serial sequence detector, together forming a combination lock. It accepts 4-bit code attempts over a valid/ready handshake and serializes each attempt MSB-first into the detector's serial input. It drives the stored secret onto the detector's compare input and samples the detector's match output after exactly four shifts. It also tracks consecutive failures, enforces a timed lockout, and allows the secret to be reprogrammed only while unlocked.

## Interface
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (≥1).
- LOCKOUT_CYC, 1000: lockout duration in clk cycles (≥1).
- CODE_RST, 4'b0000: secret value after reset.
- FCW, $clog2(MAX_FAIL+1): width of fail_cnt (derived).

- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk.
- in_code  in  4  attempted code, or new secret when prog=1.
- in_valid  in  1  requester presents in_code/prog.
- prog  in  1  qualifies in_valid as a reprogram request.
- in_ready  out  1  controller can accept; transfer on in_valid & in_ready at rising edge.
- det_a  out  1  serial bit to detector input.
- det_seq  out  4  secret driven to detector compare input.
- det_valid  in  1  detector match (combinational from its shift register).
- unlocked  out  1  lock open.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- locked_out  out  1  lockout active.
- fail_cnt  out  FCW  consecutive failures since last success/lockout end.

## Operation
- States: IDLE, SHIFT, CHECK, OPEN, LOCKOUT. Reset → IDLE.
- Reset values: in_ready=1 (IDLE), det_a=0, det_seq=CODE_RST, unlocked=0, fail_pulse=0, locked_out=0, fail_cnt=0, bit counter=0, lockout timer=0.
- in_ready = 1 in IDLE and OPEN; 0 in SHIFT, CHECK, LOCKOUT.
- IDLE: on transfer, latch in_code into attempt register, counter=0 → SHIFT. prog is ignored in IDLE; the transfer is treated as an ordinary attempt.
- SHIFT: det_a = attempt[3-counter]. Counter increments each cycle. After counter=3 → CHECK. Four detector edges fully flush any previous contents.
- CHECK: sample det_valid.
  - If det_valid=1: unlocked←1, fail_cnt←0 → OPEN.
  - If det_valid=0: fail_pulse←1 for one cycle and fail_cnt←fail_cnt+1.
    - If the new count equals MAX_FAIL: locked_out←1, timer←LOCKOUT_CYC-1 → LOCKOUT.
    - Otherwise → IDLE.
- OPEN:
  - transfer with prog=1: secret←in_code, remain OPEN. New det_seq is visible the next cycle.
  - transfer with prog=0: unlocked←0 → IDLE. in_code is discarded, not evaluated.
- LOCKOUT: timer decrements each cycle. At timer=0: locked_out←0, fail_cnt←0 → IDLE.
- det_a = 0 in all states except SHIFT. det_valid is ignored outside CHECK, so spurious matches while idle have no effect.
- Secret changes only in OPEN, so det_seq is stable throughout SHIFT and CHECK.
- in_valid held during SHIFT/CHECK/LOCKOUT is not consumed. The requester keeps it asserted until in_ready.
- fail_cnt never exceeds MAX_FAIL. It saturates at MAX_FAIL during LOCKOUT, then clears.

## Timing
- All outputs are registered; in_ready decodes directly from the state register.
- Attempt accepted at edge T:
  - det_a carries bit3 during cycle T→T+1, bit2, bit1, then bit0 during T+3→T+4.
  - The detector captures at edges T+1..T+4.
  - CHECK occupies cycle T+4→T+5.
  - unlocked or fail_pulse rises at edge T+5. Latency is 5 clocks.
- Earliest next attempt after a failure is accepted at edge T+6.
- fail_pulse is high exactly cycle T+5→T+6.
- LOCKOUT entered at edge T+5: locked_out is high for exactly LOCKOUT_CYC cycles, and in_ready returns at edge T+5+LOCKOUT_CYC.
- Reset asserted in any state, including mid-SHIFT or LOCKOUT: outputs take reset values immediately (asynchronous). The secret returns to CODE_RST, and the in-flight attempt is abandoned.

## Test plan
- Reset, default parameters, attempt 4'h0 → det_a=0,0,0,0 over 4 cycles; unlocked=1 at T+5; fail_cnt=0; fail_pulse never high.
- From OPEN, program 4'hB (prog=1), relock (prog=0), attempt 4'hB → det_a=1,0,1,1; unlocked=1 at T+5. Then relock and attempt 4'h5 → fail_pulse high one cycle at T+5, fail_cnt=1, unlocked=0.
- LOCKOUT_CYC=8, three wrong attempts → fail_cnt 1,2,3; locked_out=1 at T+5 of the third; in_ready=0 for 8 cycles; then IDLE with fail_cnt=0, locked_out=0.
- Hold in_valid with 4'h3 during SHIFT of attempt 4'hC → det_a stream stays 1,1,0,0; 4'h3 is accepted only at the first edge with in_ready=1.
- prog=1 with 4'h7 in IDLE (secret 4'h0) → treated as an attempt, fail_pulse high, secret unchanged (det_seq=4'h0).
- Program secret 4'hA, relock, assert reset_n=0 during the second SHIFT cycle → all outputs immediately at reset values; det_seq=4'h0; in_ready=1 after release.

Source files
------------

// File: rtl/seq_lock_ctrl.sv
// Sequencing controller for a 4-bit serial sequence detector forming a combination lock:
// serializes code attempts MSB-first, checks the detector match, tracks failures and lockout.
module seq_lock_ctrl #(
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 1000,
  parameter logic [3:0]  CODE_RST    = 4'b0000,
  parameter int unsigned FCW         = $clog2(MAX_FAIL + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     in_code,
  input  logic           in_valid,
  input  logic           prog,
  output logic           in_ready,
  output logic           det_a,
  output logic [3:0]     det_seq,
  input  logic           det_valid,
  output logic           unlocked,
  output logic           fail_pulse,
  output logic           locked_out,
  output logic [FCW-1:0] fail_cnt
);

  localparam int unsigned    TW         = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(LOCKOUT_CYC - 1);
  localparam logic [FCW-1:0] FAIL_LIMIT = FCW'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t         state;
  logic [1:0]     bit_cnt;
  logic [TW-1:0]  timer;
  logic [3:0]     attempt;
  logic [FCW-1:0] fail_cnt_inc;
  logic           take;

  assign in_ready     = (state == IDLE) || (state == OPEN);
  assign take         = in_valid && in_ready;
  assign fail_cnt_inc = fail_cnt + 1'b1;

  // The attempt is pure data: it is only consumed in SHIFT, which always follows a fresh load.
  always_ff @(posedge clk) begin
    if (state == IDLE && take)
      attempt <= in_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 2'd0;
      timer      <= '0;
      det_a      <= 1'b0;
      det_seq    <= CODE_RST;
      unlocked   <= 1'b0;
      fail_pulse <= 1'b0;
      locked_out <= 1'b0;
      fail_cnt   <= '0;
    end else begin
      fail_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // prog is deliberately ignored here: a locked controller never reprograms.
          if (take) begin
            bit_cnt <= 2'd0;
            det_a   <= in_code[3];
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == 2'd3) begin
            bit_cnt <= 2'd0;
            det_a   <= 1'b0;
            state   <= CHECK;
          end else begin
            bit_cnt <= bit_cnt + 2'd1;
            det_a   <= attempt[2'd2 - bit_cnt];
          end
        end
        CHECK: begin
          // The detector now holds exactly the four attempt bits, so det_valid is meaningful.
          if (det_valid) begin
            unlocked <= 1'b1;
            fail_cnt <= '0;
            state    <= OPEN;
          end else begin
            fail_pulse <= 1'b1;
            fail_cnt   <= fail_cnt_inc;
            if (fail_cnt_inc == FAIL_LIMIT) begin
              locked_out <= 1'b1;
              timer      <= TIMER_LOAD;
              state      <= LOCKOUT;
            end else begin
              state <= IDLE;
            end
          end
        end
        OPEN: begin
          if (take) begin
            if (prog) begin
              det_seq <= in_code;
            end else begin
              unlocked <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            state      <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
